// File: rtl/ysyx_2022040010_dsram_ctrl_pkg.sv
// Shared definitions for the data-SRAM access stage: access-size encodings,
// controller state type and byte-mask helpers.
package ysyx_2022040010_dsram_ctrl_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ISSUE   = 2'b01,
      CAPTURE = 2'b10,
      RESP    = 2'b11
   } state_e;

   localparam logic [7:0] MASK_B = 8'h01;
   localparam logic [7:0] MASK_H = 8'h03;
   localparam logic [7:0] MASK_W = 8'h0F;
   localparam logic [7:0] MASK_D = 8'hFF;

   // Unshifted byte mask for an access size.
   function automatic logic [7:0] base_mask(input logic [1:0] size);
      case (size)
         SZ_B:    base_mask = MASK_B;
         SZ_H:    base_mask = MASK_H;
         SZ_W:    base_mask = MASK_W;
         default: base_mask = MASK_D;
      endcase
   endfunction

   // Address offset bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] align_bits(input logic [1:0] size);
      case (size)
         SZ_B:    align_bits = 3'b000;
         SZ_H:    align_bits = 3'b001;
         SZ_W:    align_bits = 3'b011;
         default: align_bits = 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_2022040010_ld_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and
// sign/zero-extends it according to the access size.
module ysyx_2022040010_ld_align
   import ysyx_2022040010_dsram_ctrl_pkg::*;
(
   input  logic [63:0] rdata_i,
   input  logic [2:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [63:0] data_o
);

   logic [63:0] raw;
   logic        sx;

   // Lane extraction and extension; double-word ignores the unsigned flag.
   always_comb begin
      raw = rdata_i >> {off_i, 3'b000};
      sx  = ~unsigned_i;
      case (size_i)
         SZ_B:    data_o = {{56{sx & raw[7]}},  raw[7:0]};
         SZ_H:    data_o = {{48{sx & raw[15]}}, raw[15:0]};
         SZ_W:    data_o = {{32{sx & raw[31]}}, raw[31:0]};
         default: data_o = raw;
      endcase
   end

endmodule

// File: rtl/ysyx_2022040010_dsram_ctrl.sv
// Data-memory access stage: one load/store at a time from EX/MEM to the
// data SRAM port, response to WB over a valid/ready handshake.
// Optional macro DSRAM_MISALIGN_EXC_EN: misaligned requests skip the SRAM
// and respond with resp_err=1; otherwise low offset bits are forced to 0.
module ysyx_2022040010_dsram_ctrl
   import ysyx_2022040010_dsram_ctrl_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [4:0]          req_rd,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic [4:0]          resp_rd,
   output logic                resp_err,
   output logic                dsram_e,
   output logic                dsram_we,
   output logic [ADDR_W-1:0]   dsram_addr,
   output logic [DATA_W-1:0]   dsram_wdata,
   output logic [DATA_W/8-1:0] dsram_sel,
   input  logic [DATA_W-1:0]   dsram_rdata
);

   state_e              state_q, state_d;
   logic                we_q;
   logic [1:0]          size_q;
   logic                uns_q;
   logic [ADDR_W-1:3]   addr_q;
   logic [2:0]          off_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [4:0]          rd_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;

   logic [2:0]          eff_off;
   logic                go_err;
   logic [DATA_W-1:0]   ld_data;

`ifdef DSRAM_MISALIGN_EXC_EN
   assign eff_off = req_addr[2:0];
   assign go_err  = |(req_addr[2:0] & align_bits(req_size));
`else
   assign eff_off = req_addr[2:0] & ~align_bits(req_size);
   assign go_err  = 1'b0;
`endif

   ysyx_2022040010_ld_align u_ld_align (
      .rdata_i    (dsram_rdata),
      .off_i      (off_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (ld_data)
   );

   // Next-state selection for the single-outstanding access sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = go_err ? RESP : ISSUE;
         ISSUE:   state_d = we_q ? RESP : CAPTURE;
         CAPTURE: state_d = RESP;
         RESP:    if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, request latch and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr[ADDR_W-1:3];
            off_q   <= eff_off;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            rdata_q <= '0;
            err_q   <= go_err;
         end else if (state_q == CAPTURE) begin
            rdata_q <= ld_data;
         end
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = (state_q == RESP);
   assign resp_rdata  = rdata_q;
   assign resp_rd     = rd_q;
   assign resp_err    = err_q;

   assign dsram_e     = (state_q == ISSUE);
   assign dsram_we    = dsram_e & we_q;
   assign dsram_addr  = dsram_e ? {addr_q, 3'b000} : '0;
   assign dsram_sel   = dsram_e ? (base_mask(size_q) << off_q) : '0;
   assign dsram_wdata = dsram_e ? (wdata_q << {off_q, 3'b000}) : '0;

endmodule

// File: tb/tb_ysyx_2022040010_dsram_ctrl.sv
// Self-checking bench for the data-SRAM access stage: directed cases plus
// randomized transactions checked against an arithmetic reference model.
module tb_ysyx_2022040010_dsram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_err;
   logic        dsram_e;
   logic        dsram_we;
   logic [63:0] dsram_addr;
   logic [63:0] dsram_wdata;
   logic [7:0]  dsram_sel;
   logic [63:0] dsram_rdata;

   int unsigned total  = 0;
   int unsigned passes = 0;

   always #5 clk = ~clk;

   ysyx_2022040010_dsram_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_rd      (resp_rd),
      .resp_err     (resp_err),
      .dsram_e      (dsram_e),
      .dsram_we     (dsram_we),
      .dsram_addr   (dsram_addr),
      .dsram_wdata  (dsram_wdata),
      .dsram_sel    (dsram_sel),
      .dsram_rdata  (dsram_rdata)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // One complete transaction with a cycle-by-cycle SRAM model; expectations
   // come from byte-count arithmetic on the request.
   task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] word, input int unsigned hold);
      int unsigned nb, off, eff, exp_lat, exp_pulses, lat, pulses, s;
      logic        skip, rd_next;
      logic [4:0]  tag;
      logic [7:0]  exp_sel;
      logic [63:0] exp_addr, exp_wd, exp_rdata;
      logic [127:0] sh, m, v;

      nb   = 1 << sz;
      off  = addr[2:0];
`ifdef DSRAM_MISALIGN_EXC_EN
      eff  = off;
      skip = (off % nb) != 0;
`else
      eff  = off - (off % nb);
      skip = 1'b0;
`endif
      s        = ((1 << nb) - 1) << eff;
      exp_sel  = s[7:0];
      exp_addr = addr & ~64'h7;
      exp_wd   = wdata << (eff * 8);
      sh = {64'b0, word} >> (eff * 8);
      m  = (128'h1 << (nb * 8)) - 1;
      v  = sh & m;
      if (!uns && nb < 8 && sh[nb*8-1]) v = v | (~m);
      exp_rdata  = (skip || we) ? 64'h0 : v[63:0];
      exp_lat    = skip ? 1 : (we ? 2 : 3);
      exp_pulses = skip ? 0 : 1;
      tag        = 5'($urandom_range(0, 31));

      check("idle_ready", req_ready, 1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_rd       = tag;
      @(posedge clk); #1;
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = rnd64();
      req_wdata    = rnd64();
      req_rd       = 5'($urandom);

      lat = 0; pulses = 0; rd_next = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         dsram_rdata = rd_next ? word : rnd64();
         rd_next = 1'b0;
         check("busy_ready", req_ready, 0);
         if (dsram_e) begin
            pulses++;
            check("sram_we",    dsram_we,    we);
            check("sram_addr",  dsram_addr,  exp_addr);
            check("sram_sel",   dsram_sel,   exp_sel);
            check("sram_wdata", dsram_wdata, exp_wd);
            rd_next = !dsram_we;
         end else begin
            check("quiet_addr",  dsram_addr,  0);
            check("quiet_sel",   dsram_sel,   0);
            check("quiet_wdata", dsram_wdata, 0);
         end
         if (resp_valid) begin
            lat = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      check("latency", lat, exp_lat);
      check("pulses",  pulses, exp_pulses);

      if (lat != 0) begin
         check("resp_rdata", resp_rdata, exp_rdata);
         check("resp_rd",    resp_rd,    tag);
         check("resp_err",   resp_err,   skip);
         resp_ready = 1'b0;
         for (int h = 0; h < int'(hold); h++) begin
            @(posedge clk); #1;
            dsram_rdata = rnd64();
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, exp_rdata);
            check("hold_rd",    resp_rd,    tag);
            check("hold_err",   resp_err,   skip);
            check("hold_ready", req_ready,  0);
            check("hold_e",     dsram_e,    0);
         end
         resp_ready = 1'b1;
         @(posedge clk); #1;
         resp_ready = 1'b0;
         check("done_valid", resp_valid, 0);
         check("done_ready", req_ready,  1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      req_rd       = '0;
      resp_ready   = 1'b0;
      dsram_rdata  = '0;

      @(posedge clk); #1;
      check("rst_req_ready",  req_ready,  1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_rd",    resp_rd,    0);
      check("rst_resp_err",   resp_err,   0);
      check("rst_dsram_e",    dsram_e,    0);
      check("rst_dsram_we",   dsram_we,   0);
      check("rst_dsram_addr", dsram_addr, 0);
      check("rst_dsram_sel",  dsram_sel,  0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Store byte at offset 5.
      run_txn(1'b1, 2'b00, 1'b0, 64'h80000005, 64'hAB, 64'h0, 0);
      // Load half, signed then unsigned.
      run_txn(1'b0, 2'b01, 1'b0, 64'h80000002, 64'h0, 64'h00000000_80010000, 0);
      run_txn(1'b0, 2'b01, 1'b1, 64'h80000002, 64'h0, 64'h00000000_80010000, 0);
      // Load word, signed then unsigned.
      run_txn(1'b0, 2'b10, 1'b0, 64'h80000004, 64'h0, 64'h87654321_00000000, 1);
      run_txn(1'b0, 2'b10, 1'b1, 64'h80000004, 64'h0, 64'h87654321_00000000, 0);
      // Backpressure on a store double and a signed byte load.
      run_txn(1'b1, 2'b11, 1'b0, 64'h80000008, 64'h1122334455667788, 64'h0, 4);
      run_txn(1'b0, 2'b00, 1'b0, 64'h80000007, 64'h0, 64'hF1000000_00000000, 4);
      // Misaligned word load and store.
      run_txn(1'b0, 2'b10, 1'b0, 64'h80000002, 64'h0, 64'hCAFEBABE_DEADBEEF, 0);
      run_txn(1'b1, 2'b10, 1'b0, 64'h80000002, 64'h0BADF00D, 64'h0, 0);

      // Reset asserted while a load sits in CAPTURE.
      check("pre_rst_ready", req_ready, 1);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_unsigned = 1'b0;
      req_addr  = 64'h80000010; req_rd = 5'd9;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("pre_rst_issue", dsram_e, 1);
      dsram_rdata = rnd64();
      @(posedge clk); #1;
      dsram_rdata = 64'h0123456789ABCDEF;
      check("pre_rst_capture_e", dsram_e, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_req_ready",  req_ready,  1);
      check("arst_resp_valid", resp_valid, 0);
      check("arst_resp_rdata", resp_rdata, 0);
      check("arst_resp_rd",    resp_rd,    0);
      check("arst_dsram_e",    dsram_e,    0);
      check("arst_dsram_addr", dsram_addr, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         check("dropped_no_resp", resp_valid, 0);
         check("dropped_idle",    req_ready,  1);
      end

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         run_txn(1'($urandom), 2'($urandom), 1'($urandom), rnd64(), rnd64(), rnd64(),
                 $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
